// File: rtl/spi_burst_ram.sv
// spi_burst_ram: command-decoded single-port RAM with burst addressing,
// a tx_valid/tx_ready read-data handshake and sticky error flags.
module spi_burst_ram #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 8,
   parameter int MEM_DEPTH     = 256,
   parameter int PAYLOAD_WIDTH = 8,
   parameter int AUTO_INC      = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [PAYLOAD_WIDTH+1:0] din,
   input  logic                     rx_valid,
   input  logic                     tx_ready,
   input  logic                     err_clr,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     tx_valid,
   output logic                     addr_err,
   output logic                     ovf_err
);
   localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);

   logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];
   logic [1:0]               op;
   logic [PAYLOAD_WIDTH-1:0] pay;
   logic                     addr_bad, rd_ok;
   logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [DATA_WIDTH-1:0]    dout_q, dout_d;
   logic                     tx_valid_q, tx_valid_d, addr_err_q, addr_err_d, ovf_err_q, ovf_err_d;

   assign op       = din[PAYLOAD_WIDTH+1:PAYLOAD_WIDTH];
   assign pay      = din[PAYLOAD_WIDTH-1:0];
   assign addr_bad = ((pay >> ADDR_WIDTH) != '0) || ({1'b0, pay[ADDR_WIDTH-1:0]} >= DEPTH);
   assign rd_ok    = !tx_valid_q || tx_ready;

   // Wrap explicitly at the last word so non-power-of-2 depths stay in range.
   function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] a);
      return (AUTO_INC == 0) ? a : (a == LAST) ? '0 : a + 1'b1;
   endfunction

   always_ff @(posedge clk)
      if (rx_valid && op == 2'b01) mem[wr_addr_q] <= pay[DATA_WIDTH-1:0];

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      dout_d     = dout_q;
      tx_valid_d = tx_valid_q && !tx_ready;
      addr_err_d = addr_err_q && !err_clr;
      ovf_err_d  = ovf_err_q && !err_clr;
      if (rx_valid) begin
         case (op)
            2'b00: if (addr_bad) addr_err_d = 1'b1; else wr_addr_d = pay[ADDR_WIDTH-1:0];
            2'b01: wr_addr_d = nxt(wr_addr_q);
            2'b10: if (addr_bad) addr_err_d = 1'b1; else rd_addr_d = pay[ADDR_WIDTH-1:0];
            default:
               if (rd_ok) begin
                  dout_d     = mem[rd_addr_q];
                  tx_valid_d = 1'b1;
                  rd_addr_d  = nxt(rd_addr_q);
               end else ovf_err_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
         ovf_err_q  <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
         addr_err_q <= addr_err_d;
         ovf_err_q  <= ovf_err_d;
      end

   assign dout     = dout_q;
   assign tx_valid = tx_valid_q;
   assign addr_err = addr_err_q;
   assign ovf_err  = ovf_err_q;
endmodule

// File: tb/tb_spi_burst_ram.sv
// tb_spi_burst_ram: two instances (depth 200 with burst, depth 256 without)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_spi_burst_ram;
   logic        clk, rst_n, rx_valid, tx_ready, err_clr;
   logic [11:0] din;
   logic [7:0]  dout_w [2];
   logic        txv_w [2], ae_w [2], ov_w [2];
   int          checks = 0, failures = 0;

   bit [7:0] mm [2][256];
   int       wr_m [2], rd_m [2];
   bit [7:0] dout_m [2];
   bit       txv_m [2], ae_m [2], ov_m [2];
   int       depth [2] = '{200, 256};
   bit       inc [2] = '{1'b1, 1'b0};

   spi_burst_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .PAYLOAD_WIDTH(10), .AUTO_INC(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready), .err_clr(err_clr),
      .dout(dout_w[0]), .tx_valid(txv_w[0]), .addr_err(ae_w[0]), .ovf_err(ov_w[0]));
   spi_burst_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .PAYLOAD_WIDTH(10), .AUTO_INC(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready), .err_clr(err_clr),
      .dout(dout_w[1]), .tx_valid(txv_w[1]), .addr_err(ae_w[1]), .ovf_err(ov_w[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: any payload >= depth is out of range (covers bits above ADDR_WIDTH).
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            wr_m[k] = 0; rd_m[k] = 0; dout_m[k] = 0; txv_m[k] = 0; ae_m[k] = 0; ov_m[k] = 0;
         end else begin
            automatic bit       accept = !txv_m[k] || tx_ready;
            automatic int       pay    = int'(din[9:0]);
            if (txv_m[k] && tx_ready) txv_m[k] = 0;
            if (err_clr) begin ae_m[k] = 0; ov_m[k] = 0; end
            if (rx_valid) begin
               case (din[11:10])
                  2'd0: if (pay >= depth[k]) ae_m[k] = 1; else wr_m[k] = pay;
                  2'd1: begin
                     mm[k][wr_m[k]] = din[7:0];
                     if (inc[k]) wr_m[k] = (wr_m[k] + 1) % depth[k];
                  end
                  2'd2: if (pay >= depth[k]) ae_m[k] = 1; else rd_m[k] = pay;
                  default:
                     if (accept) begin
                        dout_m[k] = mm[k][rd_m[k]];
                        txv_m[k]  = 1;
                        if (inc[k]) rd_m[k] = (rd_m[k] + 1) % depth[k];
                     end else ov_m[k] = 1;
               endcase
            end
         end
      end
   end

   always @(negedge clk)
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("model dout[%0d]", k), 32'(dout_w[k]), 32'(dout_m[k]));
         chk($sformatf("model tx_valid[%0d]", k), 32'(txv_w[k]), 32'(txv_m[k]));
         chk($sformatf("model addr_err[%0d]", k), 32'(ae_w[k]), 32'(ae_m[k]));
         chk($sformatf("model ovf_err[%0d]", k), 32'(ov_w[k]), 32'(ov_m[k]));
      end

   task automatic cmd(input logic [1:0] op, input logic [9:0] pay);
      din = {op, pay};
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; din = '0; rx_valid = 1'b0; tx_ready = 1'b1; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("reset dout", 32'(dout_w[0]), 32'h0);
      chk("reset tx_valid", 32'(txv_w[0]), 32'h0);
      cmd(2'd0, 10'd0);
      for (int i = 0; i < 256; i++) cmd(2'd1, 10'($urandom));
      // burst write/read
      cmd(2'd0, 10'h10);
      cmd(2'd1, 10'hA1); cmd(2'd1, 10'hA2); cmd(2'd1, 10'hA3);
      cmd(2'd2, 10'h10);
      cmd(2'd3, 10'd0); chk("burst rd0", 32'(dout_w[0]), 32'hA1); chk("burst txv0", 32'(txv_w[0]), 32'h1);
      cmd(2'd3, 10'd0); chk("burst rd1", 32'(dout_w[0]), 32'hA2); chk("burst txv1", 32'(txv_w[0]), 32'h1);
      cmd(2'd3, 10'd0); chk("burst rd2", 32'(dout_w[0]), 32'hA3);
      @(negedge clk);   chk("burst drain", 32'(txv_w[0]), 32'h0); chk("burst hold", 32'(dout_w[0]), 32'hA3);
      // backpressure
      tx_ready = 1'b0;
      cmd(2'd0, 10'h20); cmd(2'd1, 10'h11); cmd(2'd1, 10'h22); cmd(2'd2, 10'h20);
      cmd(2'd3, 10'd0); chk("bp first", 32'(dout_w[0]), 32'h11); chk("bp ovf clear", 32'(ov_w[0]), 32'h0);
      cmd(2'd3, 10'd0); chk("bp ovf", 32'(ov_w[0]), 32'h1); chk("bp dout hold", 32'(dout_w[0]), 32'h11);
      chk("bp txv hold", 32'(txv_w[0]), 32'h1);
      tx_ready = 1'b1;
      @(negedge clk);   chk("bp drain", 32'(txv_w[0]), 32'h0);
      err_clr = 1'b1;
      @(negedge clk);   chk("ovf cleared", 32'(ov_w[0]), 32'h0);
      err_clr = 1'b0;
      cmd(2'd3, 10'd0); chk("bp advanced once", 32'(dout_w[0]), 32'h22);
      // wrap at non-power-of-2 depth
      cmd(2'd0, 10'd199); cmd(2'd1, 10'h55); cmd(2'd1, 10'h66);
      cmd(2'd2, 10'd199);
      cmd(2'd3, 10'd0); chk("wrap 199", 32'(dout_w[0]), 32'h55);
      cmd(2'd3, 10'd0); chk("wrap 0", 32'(dout_w[0]), 32'h66);
      // range errors
      cmd(2'd0, 10'd100); cmd(2'd1, 10'h3C); cmd(2'd2, 10'd100);
      cmd(2'd2, 10'd250); chk("range 250", 32'(ae_w[0]), 32'h1); chk("range ok dut1", 32'(ae_w[1]), 32'h0);
      cmd(2'd3, 10'd0); chk("range rd kept", 32'(dout_w[0]), 32'h3C);
      err_clr = 1'b1;
      @(negedge clk);   chk("err_clr alone", 32'(ae_w[0]), 32'h0);
      cmd(2'd2, 10'd250); chk("set beats clr", 32'(ae_w[0]), 32'h1);
      @(negedge clk);   chk("clr after", 32'(ae_w[0]), 32'h0);
      err_clr = 1'b0;
      cmd(2'd2, 10'h105); chk("upper bit dut0", 32'(ae_w[0]), 32'h1); chk("upper bit dut1", 32'(ae_w[1]), 32'h1);
      // no auto-increment
      cmd(2'd0, 10'd5); cmd(2'd1, 10'h77); cmd(2'd2, 10'd5);
      cmd(2'd3, 10'd0); chk("noinc rd0", 32'(dout_w[1]), 32'h77);
      cmd(2'd3, 10'd0); chk("noinc rd1", 32'(dout_w[1]), 32'h77);
      repeat (3) @(negedge clk);
      chk("noinc idle dout", 32'(dout_w[1]), 32'h77); chk("noinc idle txv", 32'(txv_w[1]), 32'h0);
      // asynchronous reset mid-cycle
      tx_ready = 1'b0;
      cmd(2'd3, 10'd0);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("async dout[%0d]", k), 32'(dout_w[k]), 32'h0);
         chk($sformatf("async txv[%0d]", k), 32'(txv_w[k]), 32'h0);
         chk($sformatf("async ae[%0d]", k), 32'(ae_w[k]), 32'h0);
         chk($sformatf("async ov[%0d]", k), 32'(ov_w[k]), 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            rx_valid = 1'b0;
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
            @(negedge clk);
         end else begin
            automatic logic [1:0] op = 2'($urandom_range(0, 3));
            automatic int r = $urandom_range(0, 9);
            automatic logic [9:0] pay = (op[0]) ? 10'($urandom) :
                                        (r < 7) ? 10'($urandom_range(0, 255)) :
                                        (r < 9) ? 10'($urandom_range(190, 210)) : 10'($urandom_range(0, 1023));
            din      = {op, pay};
            rx_valid = ($urandom_range(0, 9) < 7);
            tx_ready = 1'($urandom_range(0, 1));
            err_clr  = ($urandom_range(0, 19) == 0);
            @(negedge clk);
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
